// File: rtl/mod_74x08_bist_ctrl_pkg.sv
// Shared definitions for the 74x08 quad-AND bank BIST controller:
// FSM state encodings, vector-space constants and the vector-to-operand mapping.
package mod_74x08_bist_ctrl_pkg;

    localparam int unsigned GATE_W    = 3;
    localparam int unsigned VEC_W     = 6;
    localparam int unsigned VEC_COUNT = 64;
    localparam int unsigned ERR_W     = 7;
    localparam int unsigned SETTLE_W  = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(VEC_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_e;

    // Operand pair driven onto the gate bank for one test vector.
    typedef struct packed {
        logic [0:GATE_W-1] a;
        logic [0:GATE_W-1] b;
    } gate_operands_t;

    // Upper three index bits feed A (MSB first), lower three feed B.
    function automatic gate_operands_t vec_to_operands(input logic [VEC_W-1:0] v);
        gate_operands_t op;
        op.a[0] = v[5];
        op.a[1] = v[4];
        op.a[2] = v[3];
        op.b[0] = v[2];
        op.b[1] = v[1];
        op.b[2] = v[0];
        return op;
    endfunction

endpackage

// File: rtl/mod_74x08_bist_ctrl_bist_settle_timer.sv
// Settle-delay down-counter: load a cycle count, count down to zero,
// expire_c is high during the final counted cycle.
module bist_settle_timer
    import mod_74x08_bist_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expire_c
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Next count: clear wins over load, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/mod_74x08_bist_ctrl.sv
// BIST controller for a three-gate AND bank: walks all 64 operand vectors,
// waits SETTLE_CYCLES per vector, compares Y against A&B and counts mismatches.
// Optional first-failing-vector capture: define BIST_FIRST_FAIL_CAPTURE_EN.
module mod_74x08_bist_ctrl
    import mod_74x08_bist_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [0:GATE_W-1]   Y,
    output logic [0:GATE_W-1]   A,
    output logic [0:GATE_W-1]   B,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [ERR_W-1:0]    ERR_CNT
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [VEC_W-1:0]    FAIL_VEC,
    output logic                FAIL_VALID
`endif
);

    bist_state_e state_q, state_d;

    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [0:GATE_W-1] a_q, a_d;
    logic [0:GATE_W-1] b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    logic [VEC_W-1:0]  fail_vec_q, fail_vec_d;
    logic              fail_valid_q, fail_valid_d;
`endif

    logic              timer_load;
    logic              timer_clr;
    logic              timer_expire_c;
    logic              vec_mismatch_c;
    gate_operands_t    next_ops;

    bist_settle_timer u_settle_timer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (timer_clr),
        .load     (timer_load),
        .load_val (SETTLE_W'(SETTLE_CYCLES)),
        .expire_c (timer_expire_c)
    );

    // Any differing output bit marks the whole vector as failing.
    assign vec_mismatch_c = (Y != (a_q & b_q));

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_cnt_d    = err_cnt_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        timer_load   = 1'b0;
        timer_clr    = 1'b0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // START beats a simultaneous ABORT here.
                if (START) begin
                    state_d   = ST_APPLY;
                    vec_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
`endif
                end
            end

            ST_APPLY: begin
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    timer_clr = 1'b1;
                end else if (SETTLE_CYCLES == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d    = ST_SETTLE;
                    timer_load = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    timer_clr = 1'b1;
                end else if (timer_expire_c) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    timer_clr = 1'b1;
                end else begin
                    if (vec_mismatch_c) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
                        if (!fail_valid_q) begin
                            fail_vec_d   = vec_q;
                            fail_valid_d = 1'b1;
                        end
`endif
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                        vec_d   = vec_q + VEC_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // An abort landing on the completion cycle suppresses the result.
                state_d = ST_IDLE;
                if (!ABORT) begin
                    done_d = 1'b1;
                    pass_d = (err_cnt_q == '0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operands and BUSY follow the state being entered so they line up with it.
        busy_d   = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        next_ops = vec_to_operands(vec_d);
        a_d      = busy_d ? next_ops.a : '0;
        b_d      = busy_d ? next_ops.b : '0;
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
`endif
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign ERR_CNT = err_cnt_q;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    assign FAIL_VEC   = fail_vec_q;
    assign FAIL_VALID = fail_valid_q;
`endif

endmodule

// File: tb/tb_mod_74x08_bist_ctrl.sv
// Bench for mod_74x08_bist_ctrl: a SETTLE_CYCLES=2 and a SETTLE_CYCLES=0 instance
// share the control inputs; each drives its own modelled (optionally faulty) gate bank.
module tb_mod_74x08_bist_ctrl;

    localparam int NV = 64;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [0:2] y2, a2, b2, y0, a0, b0;
    logic busy2, done2, pass2, busy0, done0, pass0;
    logic [6:0] err2, err0;
    logic [5:0] fv2, fv0;
    logic fvl2, fvl0;
    int fault_mode;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state per instance: k=0 -> SETTLE 2, k=1 -> SETTLE 0
    bit m_run[2];
    int m_t[2];
    int m_err[2];
    bit m_pass[2];
    bit m_done[2];
    int m_fv[2];
    bit m_fvalid[2];

    always #5 clk = ~clk;

    // Gate bank under test with selectable fault.
    function automatic logic [0:2] bank(input logic [0:2] a, input logic [0:2] b, input int fm);
        logic [0:2] y;
        y = a & b;
        case (fm)
            1: y = 3'b000;
            2: y[1] = 1'b1;
            default: ;
        endcase
        return y;
    endfunction

    function automatic bit vec_fails(input int v, input int fm);
        logic [5:0] vv;
        logic [0:2] a, b;
        vv = 6'(v);
        a = vv[5:3];
        b = vv[2:0];
        return bank(a, b, fm) != (a & b);
    endfunction

    function automatic int period(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    assign y2 = bank(a2, b2, fault_mode);
    assign y0 = bank(a0, b0, fault_mode);

    mod_74x08_bist_ctrl #(.SETTLE_CYCLES(2)) dut_s2 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .Y(y2),
        .A(a2), .B(b2), .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2)
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        , .FAIL_VEC(fv2), .FAIL_VALID(fvl2)
`endif
    );

    mod_74x08_bist_ctrl #(.SETTLE_CYCLES(0)) dut_s0 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .Y(y0),
        .A(a0), .B(b0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0)
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        , .FAIL_VEC(fv0), .FAIL_VALID(fvl0)
`endif
    );

`ifndef BIST_FIRST_FAIL_CAPTURE_EN
    assign fv2 = 6'd0;
    assign fvl2 = 1'b0;
    assign fv0 = 6'd0;
    assign fvl0 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is 64 vectors of period SETTLE+2 cycles, then one DONE-state cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] <= 1'b0; m_t[k] <= 0; m_err[k] <= 0; m_pass[k] <= 1'b0;
                m_done[k] <= 1'b0; m_fv[k] <= 0; m_fvalid[k] <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (!m_run[k]) begin
                    if (start) begin
                        m_run[k] <= 1'b1; m_t[k] <= 0; m_err[k] <= 0; m_pass[k] <= 1'b0;
                        m_fv[k] <= 0; m_fvalid[k] <= 1'b0;
                    end
                end else if (abort) begin
                    m_run[k] <= 1'b0;
                end else if (m_t[k] == NV * period(k)) begin
                    m_run[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_pass[k] <= (m_err[k] == 0);
                end else begin
                    if (m_t[k] % period(k) == period(k) - 1) begin
                        if (vec_fails(m_t[k] / period(k), fault_mode)) begin
                            m_err[k] <= m_err[k] + 1;
                            if (!m_fvalid[k]) begin
                                m_fvalid[k] <= 1'b1;
                                m_fv[k] <= m_t[k] / period(k);
                            end
                        end
                    end
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic busy, input logic done, input logic pass,
                       input logic [6:0] err, input logic [0:2] a, input logic [0:2] b,
                       input logic [5:0] fv, input logic fvl);
        logic exp_busy;
        logic [5:0] vv;
        logic [0:2] ea, eb;
        exp_busy = m_run[k] && (m_t[k] < NV * period(k));
        vv = 6'(m_t[k] / period(k));
        ea = exp_busy ? vv[5:3] : 3'b000;
        eb = exp_busy ? vv[2:0] : 3'b000;
        chk($sformatf("m%0d_busy", k), busy, exp_busy);
        chk($sformatf("m%0d_done", k), done, m_done[k]);
        chk($sformatf("m%0d_pass", k), pass, m_pass[k]);
        chk($sformatf("m%0d_err", k), err, m_err[k]);
        chk($sformatf("m%0d_a", k), a, ea);
        chk($sformatf("m%0d_b", k), b, eb);
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        chk($sformatf("m%0d_fvalid", k), fvl, m_fvalid[k]);
        chk($sformatf("m%0d_fvec", k), fv, m_fv[k]);
`else
        if (fvl !== 1'b0 || fv !== 6'd0) ;
`endif
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, busy2, done2, pass2, err2, a2, b2, fv2, fvl2);
            cmp(1, busy0, done0, pass0, err0, a0, b0, fv0, fvl0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full run with hand-computed latency and result expectations.
    task automatic run_full(input int fm, input int exp_err, input bit exp_pass,
                            input int exp_fv, input bit with_abort, input int repulse_at);
        int lat2, lat0;
        fault_mode = fm;
        start = 1'b1;
        abort = with_abort;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk("started_s2", busy2, 1'b1);
        chk("started_s0", busy0, 1'b1);
        lat2 = -1;
        lat0 = -1;
        for (int n = 1; n <= 400 && (lat2 < 0 || lat0 < 0); n++) begin
            @(posedge clk);
            #1;
            start = (n == repulse_at);
            if (done2 && lat2 < 0) lat2 = n;
            if (done0 && lat0 < 0) lat0 = n;
        end
        start = 1'b0;
        chk("latency_s2", 32'(lat2), 32'd257);
        chk("latency_s0", 32'(lat0), 32'd129);
        chk("err_s2", err2, 32'(exp_err));
        chk("err_s0", err0, 32'(exp_err));
        chk("pass_s2", pass2, exp_pass);
        chk("pass_s0", pass0, exp_pass);
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        chk("fvalid_s2", fvl2, exp_err != 0);
        chk("fvec_s2", fv2, 32'(exp_fv));
        chk("fvec_s0", fv0, 32'(exp_fv));
`endif
        cyc(3);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        fault_mode = 0;
        cyc(3);
        chk_en = 1'b1;
        chk("rst_busy", busy2, 1'b0);
        chk("rst_done", done2, 1'b0);
        chk("rst_pass", pass2, 1'b0);
        chk("rst_err", err2, 32'd0);
        chk("rst_a", a2, 32'd0);
        rst = 1'b0;
        cyc(2);

        run_full(0, 0, 1'b1, 0, 1'b0, 0);
        run_full(1, 37, 1'b0, 9, 1'b0, 0);
        run_full(2, 48, 1'b0, 0, 1'b0, 0);
        run_full(0, 0, 1'b1, 0, 1'b1, 60);

        // Abort 50 cycles into a stuck-at-0 run.
        fault_mode = 1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(50);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy_s2", busy2, 1'b0);
        chk("abort_busy_s0", busy0, 1'b0);
        chk("abort_a_s2", a2, 32'd0);
        chk("abort_b_s2", b2, 32'd0);
        chk("abort_pass_s2", pass2, 1'b0);
        chk("abort_err_s2", err2, 32'd2);
        chk("abort_err_s0", err0, 32'd8);
        ndone = 0;
        for (int n = 0; n < 300; n++) begin
            cyc(1);
            if (done2 || done0) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Reset mid-run.
        fault_mode = 2;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(100);
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        chk("midrst_busy", busy2, 1'b0);
        chk("midrst_err_s2", err2, 32'd0);
        chk("midrst_err_s0", err0, 32'd0);
        chk("midrst_a", a2, 32'd0);
        chk("midrst_b", b0, 32'd0);
        chk("midrst_pass", pass2, 1'b0);
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        chk("midrst_fvalid", fvl2, 1'b0);
`endif
        cyc(5);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_74x08_bist_ctrl.md
MOD_74X08_BIST_CTRL -- requirements
Module: mod_74x08_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 0..15: idle cycles between driving a vector and sampling Y.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  single-cycle request to begin a self-test run.
REQ-005 ABORT  in  1  terminate a running test.
REQ-006 Y  in  [0:2]  outputs of the three-gate AND bank under test.
REQ-007 A, B  out  [0:2] each  operands driven to the gate bank.
REQ-008 BUSY  out  1  high while a run is in progress.
REQ-009 DONE  out  1  one-cycle pulse at normal completion.
REQ-010 PASS  out  1  high when the last completed run had zero mismatches.
REQ-011 ERR_CNT  out  [6:0]  mismatch count of the current or last run.
REQ-012 FAIL_VEC  out  [5:0], FAIL_VALID  out  1  first failing vector index (present only when enabled, see Configuration).

Function
REQ-013 FSM states IDLE, APPLY, SETTLE, CHECK, DONE; IDLE->APPLY on START, APPLY->SETTLE (or CHECK when SETTLE_CYCLES=0), SETTLE->CHECK after SETTLE_CYCLES cycles, CHECK->APPLY if index<63, else CHECK->DONE, DONE->IDLE unconditionally.
REQ-014 Vector index v (6 bits) runs 0..63, exhaustive; A[0]=v[5], A[1]=v[4], A[2]=v[3], B[0]=v[2], B[1]=v[1], B[2]=v[0].
REQ-015 A/B hold the current vector from APPLY through CHECK; A=B=0 in IDLE and DONE.
REQ-016 In CHECK, Y is compared bitwise with A&B; any mismatching bit increments ERR_CNT by exactly 1 per vector.
REQ-017 Run length: DONE pulses exactly 64*(SETTLE_CYCLES+2)+1 cycles after the edge that samples START.
REQ-018 ERR_CNT clears and PASS drops on the edge sampling START; PASS is set in DONE iff ERR_CNT=0 and holds until the next START.
REQ-019 START while BUSY is ignored; START and ABORT together in IDLE: START wins.
REQ-020 ABORT in any non-IDLE state: next state IDLE, A=B=0, no DONE pulse, PASS stays 0, ERR_CNT frozen.
REQ-021 BUSY is high in APPLY, SETTLE, CHECK and low in IDLE, DONE.

Reset
REQ-022 RST forces IDLE, v=0, A=B=0, BUSY=DONE=PASS=0, ERR_CNT=0, FAIL_VEC=0, FAIL_VALID=0, including mid-run; RST overrides START and ABORT.

Configuration
REQ-023 Macro BIST_FIRST_FAIL_CAPTURE_EN defined: FAIL_VEC/FAIL_VALID exist; the first mismatching v of a run is latched and FAIL_VALID set, both cleared on START.
REQ-024 Macro undefined: FAIL_VEC and FAIL_VALID ports and logic are absent; all other behaviour unchanged.

Structure
REQ-025 Shared package/header holds the FSM state encodings, vector count constant 64, and vector-to-A/B bit mapping.
REQ-026 Settle delay is a sub-module bist_settle_timer (load, count down, expire pulse).

Verification
REQ-027 Y=A&B model, SETTLE_CYCLES=2, START pulse -> DONE exactly 257 cycles later, PASS=1, ERR_CNT=0, FAIL_VALID=0.
REQ-028 Y stuck 3'b000 -> ERR_CNT=37, PASS=0, FAIL_VEC=9 (A=3'b001, B=3'b001).
REQ-029 Y[1] stuck 1, others correct -> ERR_CNT=48, FAIL_VEC=0.
REQ-030 Correct model, ABORT 50 cycles into run -> IDLE next cycle, BUSY=0, A=B=0, DONE never pulses, PASS=0.
REQ-031 START re-pulsed mid-run -> ignored, DONE still at cycle 257; RST mid-run -> all outputs zero next cycle.
REQ-032 SETTLE_CYCLES=0, correct model -> DONE 129 cycles after START, PASS=1.
